ins_fetch_queue: RTL and testbench
==================================

INS_FETCH_QUEUE -- requirements
Module: ins_fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 16, program address width.
REQ-002 Parameter DATA_W, default 8, program memory data width.
REQ-003 Parameter DEPTH, default 4, prefetch queue entries; power of two, 2..16.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 fetch_en  input  1  1 = prefetch allowed; 0 = no new bus cycle started.
REQ-007 jmp_en  input  1  one-cycle redirect strobe.
REQ-008 jmp_addr  input  ADDR_W  redirect target address.
REQ-009 mem_addr  output  ADDR_W  program memory address, registered.
REQ-010 mem_ale  output  1  address latch strobe, high for exactly one cycle per bus cycle.
REQ-011 mem_psen_n  output  1  program read strobe, active-low.
REQ-012 mem_data  input  DATA_W  program memory read data.
REQ-013 mem_ready  input  1  read data valid, sampled only while mem_psen_n = 0.
REQ-014 ins_valid  output  1  queue head valid.
REQ-015 ins_data  output  DATA_W  queue head byte.
REQ-016 ins_pc  output  ADDR_W  address the head byte was fetched from.
REQ-017 ins_ack  input  1  consumer pops head; ignored when ins_valid = 0.
REQ-018 q_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 FSM states IDLE, ADDR, READ; one bus cycle in flight at most.
REQ-020 IDLE -> ADDR when fetch_en = 1, jmp_en = 0 and q_count < DEPTH; else stay.
REQ-021 ADDR: mem_ale = 1, mem_addr = fetch_pc, mem_psen_n = 1; always -> READ after one cycle.
REQ-022 READ: mem_ale = 0, mem_psen_n = 0, mem_addr held; wait indefinitely for mem_ready = 1.
REQ-023 READ with mem_ready = 1: push {mem_data, fetch_pc}; fetch_pc increments by 1 modulo 2^ADDR_W (0xFFFF -> 0x0000 at default); -> ADDR if post-push occupancy < DEPTH and fetch_en = 1, else IDLE.
REQ-024 Sustained throughput with mem_ready tied high: one byte per two clocks.
REQ-025 Queue is FIFO; ins_data/ins_pc/ins_valid reflect head combinationally from registered storage; pop and push in same cycle keep q_count unchanged.
REQ-026 Push never occurs when full: fetch starts only with q_count < DEPTH and pops only reduce occupancy during READ.
REQ-027 jmp_en = 1 in any state: queue cleared (q_count = 0, ins_valid = 0 next cycle), in-flight read aborted and its data discarded even if mem_ready = 1 that cycle, fetch_pc <= jmp_addr, FSM -> IDLE.
REQ-028 jmp_en has priority over simultaneous ins_ack and push.
REQ-029 fetch_en deasserted mid bus cycle: current cycle completes and pushes; no new cycle starts.
REQ-030 mem_psen_n and mem_ale never active in the same cycle.

Reset
REQ-031 rst_n low: state IDLE, fetch_pc = 0, queue empty, q_count = 0, ins_valid = 0, mem_addr = 0, mem_ale = 0, mem_psen_n = 1, ins_data = 0, ins_pc = 0; immediate, independent of clk.
REQ-032 rst_n asserted mid READ: bus cycle abandoned, no push; after release first fetch from address 0.

Verification
REQ-033 Reset release, fetch_en = 1, mem_ready = 1, mem[0..3] = 02,00,10,E4 -> ale at edges 1,3,5,7; ins_valid first high after edge 3 with ins_data = 02, ins_pc = 0000.
REQ-034 No ins_ack, DEPTH = 4 -> q_count reaches 4, FSM parks in IDLE, mem_psen_n stays 1; one ins_ack -> next fetch address 0004 starts next cycle.
REQ-035 mem_ready low 5 cycles in READ -> mem_psen_n held low, mem_addr stable, single push when mem_ready rises.
REQ-036 jmp_en with jmp_addr = 0x0100 during READ with mem_ready = 1 and ins_ack = 1 same cycle -> no push, q_count = 0 next cycle, next ale address 0x0100.
REQ-037 jmp_addr = 0xFFFF -> bytes fetched with ins_pc FFFF then 0000.
REQ-038 rst_n pulsed low mid READ -> all outputs at reset values within the same cycle, restart at 0000.

Source files
------------

// File: rtl/ins_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ins_fetch_queue
// Purpose  : Instruction prefetch engine. It runs a two-phase program memory
//            bus (address latch cycle, then read strobe cycle) and fills a
//            small FIFO of {byte, address} pairs for the decoder. A jump
//            redirect flushes the queue and aborts any read in flight.
// Ports    : clk, rst_n        - clock, async active-low reset
//            fetch_en          - allow new bus cycles to start
//            jmp_en, jmp_addr  - one-cycle redirect strobe and target
//            mem_addr, mem_ale, mem_psen_n - registered bus outputs
//            mem_data, mem_ready           - read data and its valid
//            ins_valid, ins_data, ins_pc   - queue head
//            ins_ack           - consumer pops the head
//            q_count           - queue occupancy
// Revision : 1.0 - initial release
// ============================================================================
module ins_fetch_queue #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  input  logic                     jmp_en,
  input  logic [ADDR_W-1:0]        jmp_addr,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_ale,
  output logic                     mem_psen_n,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_ready,
  output logic                     ins_valid,
  output logic [DATA_W-1:0]        ins_data,
  output logic [ADDR_W-1:0]        ins_pc,
  input  logic                     ins_ack,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_READ = 2'd2
  } state_t;

  state_t             r_state;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_mem_ale;
  logic               r_mem_psen_n;

  logic [DATA_W-1:0]  r_q_data [DEPTH];
  logic [ADDR_W-1:0]  r_q_pc   [DEPTH];
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_count_next;
  logic [ADDR_W-1:0]  w_pc_inc;

  // A redirect wins over both queue operations: data returned in the same
  // cycle as a jump belongs to the abandoned stream.
  assign w_push   = (r_state == ST_READ) && mem_ready && !jmp_en;
  assign w_pop    = ins_ack && (r_count != '0) && !jmp_en;
  assign w_pc_inc = r_fetch_pc + 1'b1;

  // Occupancy after this edge; the READ exit decision uses it so a pop in
  // the completing cycle frees a slot for the next fetch immediately.
  always_comb begin
    w_count_next = r_count;
    if (jmp_en) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + 1'b1;
        2'b01:   w_count_next = r_count - 1'b1;
        default: w_count_next = r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Bus sequencer. Outputs are registered and updated together with the
  // state so ale and psen_n can never overlap.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_fetch_pc   <= '0;
      r_mem_addr   <= '0;
      r_mem_ale    <= 1'b0;
      r_mem_psen_n <= 1'b1;
    end else if (jmp_en) begin
      r_state      <= ST_IDLE;
      r_fetch_pc   <= jmp_addr;
      r_mem_ale    <= 1'b0;
      r_mem_psen_n <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mem_ale    <= 1'b0;
          r_mem_psen_n <= 1'b1;
          if (fetch_en && (r_count < c_full)) begin
            r_state    <= ST_ADDR;
            r_mem_ale  <= 1'b1;
            r_mem_addr <= r_fetch_pc;
          end
        end
        ST_ADDR: begin
          r_state      <= ST_READ;
          r_mem_ale    <= 1'b0;
          r_mem_psen_n <= 1'b0;
        end
        ST_READ: begin
          // Address is held and psen_n stays low until data arrives.
          if (mem_ready) begin
            r_fetch_pc <= w_pc_inc;
            if (fetch_en && (w_count_next < c_full)) begin
              r_state      <= ST_ADDR;
              r_mem_ale    <= 1'b1;
              r_mem_psen_n <= 1'b1;
              r_mem_addr   <= w_pc_inc;
            end else begin
              r_state      <= ST_IDLE;
              r_mem_ale    <= 1'b0;
              r_mem_psen_n <= 1'b1;
            end
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_mem_ale    <= 1'b0;
          r_mem_psen_n <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Prefetch FIFO. DEPTH is a power of two so the pointers wrap naturally.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (jmp_en) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_data[r_wr_ptr] <= mem_data;
        r_q_pc[r_wr_ptr]   <= r_fetch_pc;
        r_wr_ptr           <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_ale    = r_mem_ale;
  assign mem_psen_n = r_mem_psen_n;

  assign ins_valid  = (r_count != '0);
  assign ins_data   = r_q_data[r_rd_ptr];
  assign ins_pc     = r_q_pc[r_rd_ptr];
  assign q_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_fetch_queue
// Purpose  : Self-checking bench for ins_fetch_queue. A byte-array program
//            memory answers the bus; the reference model is simply "the
//            consumer sees mem[pc], mem[pc+1], ... starting from the last
//            reset or jump target". Expected head values are queued when the
//            bench issues an ack and a negedge monitor compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_fetch_queue;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  fetch_en;
  logic                  jmp_en;
  logic [ADDR_W-1:0]     jmp_addr;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_ale;
  logic                  mem_psen_n;
  logic [DATA_W-1:0]     mem_data;
  logic                  mem_ready;
  logic                  ins_valid;
  logic [DATA_W-1:0]     ins_data;
  logic [ADDR_W-1:0]     ins_pc;
  logic                  ins_ack;
  logic [$clog2(DEPTH):0] q_count;

  ins_fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_en   (fetch_en),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .mem_addr   (mem_addr),
    .mem_ale    (mem_ale),
    .mem_psen_n (mem_psen_n),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .ins_valid  (ins_valid),
    .ins_data   (ins_data),
    .ins_pc     (ins_pc),
    .ins_ack    (ins_ack),
    .q_count    (q_count)
  );

  logic [7:0] mem [0:65535];
  assign mem_data = mem[mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_err  = 0;
  int n_pops = 0;

  logic [23:0] exp_q [$];
  logic [15:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // One clock of stimulus. Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic fe, input logic jmp, input logic [15:0] ja,
                      input logic ack, input logic rdy);
    fetch_en  = fe;
    jmp_en    = jmp;
    jmp_addr  = ja;
    ins_ack   = ack;
    mem_ready = rdy;
    if (jmp) begin
      exp_pc = ja;
    end else if (ack && ins_valid) begin
      exp_q.push_back({mem[exp_pc], exp_pc});
      exp_pc = exp_pc + 16'd1;
    end
    @(posedge clk);
    #1;
    if (jmp) begin
      chk("jmp_clears_count", 32'(q_count), 32'd0);
      chk("jmp_clears_valid", 32'(ins_valid), 32'd0);
    end
  endtask

  // Scoreboard monitor: a pop happens at the coming posedge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ins_valid === 1'b1 && ins_ack === 1'b1 && jmp_en === 1'b0) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected_pop: got pc %h data %h expected nothing", ins_pc, ins_data);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("sb_head", {8'h0, ins_data, ins_pc}, {8'h0, e});
      end
    end
    if (rst_n === 1'b1) begin
      n_cmp++;
      if (mem_ale === 1'b1 && mem_psen_n === 1'b0) begin
        n_err++;
        $display("FAIL ale_psen_overlap: got ale=1 psen_n=0 required not both active");
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    chk({tag, "_mem_ale"},    32'(mem_ale),    32'd0);
    chk({tag, "_mem_psen_n"}, 32'(mem_psen_n), 32'd1);
    chk({tag, "_ins_valid"},  32'(ins_valid),  32'd0);
    chk({tag, "_q_count"},    32'(q_count),    32'd0);
    chk({tag, "_ins_data"},   32'(ins_data),   32'd0);
    chk({tag, "_ins_pc"},     32'(ins_pc),     32'd0);
  endtask

  logic [15:0] saved_addr;
  int          guard;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h02; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'hE4;
    rst_n = 1'b1; fetch_en = 1'b0; jmp_en = 1'b0; jmp_addr = '0;
    ins_ack = 1'b0; mem_ready = 1'b0; exp_pc = 16'd0;

    // Reset values
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Release with fetch enabled and memory always ready
    rst_n = 1'b1; exp_pc = 16'd0;
    for (int k = 1; k <= 9; k++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      chk($sformatf("ale_edge%0d", k), 32'(mem_ale), 32'(k % 2 == 1 && k <= 7));
      if (k % 2 == 1 && k <= 7) chk($sformatf("ale_addr_edge%0d", k), 32'(mem_addr), 32'((k - 1) / 2));
      if (k == 2) chk("valid_edge2", 32'(ins_valid), 32'd0);
      if (k == 3) begin
        chk("valid_edge3", 32'(ins_valid), 32'd1);
        chk("data_edge3", 32'(ins_data), 32'h02);
        chk("pc_edge3", 32'(ins_pc), 32'h0000);
      end
    end
    chk("full_count", 32'(q_count), 32'd4);

    // Parked while full
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      chk("parked_psen_n", 32'(mem_psen_n), 32'd1);
      chk("parked_ale", 32'(mem_ale), 32'd0);
      chk("parked_count", 32'(q_count), 32'd4);
    end
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("pop_count", 32'(q_count), 32'd3);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("refetch_ale", 32'(mem_ale), 32'd1);
    chk("refetch_addr", 32'(mem_addr), 32'h0004);

    // Wait states in READ
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("read_psen_n", 32'(mem_psen_n), 32'd0);
    saved_addr = mem_addr;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      chk("wait_psen_n", 32'(mem_psen_n), 32'd0);
      chk("wait_addr", 32'(mem_addr), 32'(saved_addr));
      chk("wait_count", 32'(q_count), 32'd3);
    end
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("ready_push_count", 32'(q_count), 32'd4);
    chk("ready_psen_n", 32'(mem_psen_n), 32'd1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("single_push_count", 32'(q_count), 32'd4);

    // Jump during READ with ready and ack in the same cycle
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("pre_jmp_ale", 32'(mem_ale), 32'd1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("pre_jmp_psen_n", 32'(mem_psen_n), 32'd0);
    step(1'b1, 1'b1, 16'h0100, 1'b1, 1'b1);
    chk("jmp_psen_n", 32'(mem_psen_n), 32'd1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("jmp_ale", 32'(mem_ale), 32'd1);
    chk("jmp_ale_addr", 32'(mem_addr), 32'h0100);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("jmp_first_pc", 32'(ins_pc), 32'h0100);
    chk("jmp_first_data", 32'(ins_data), 32'(mem[16'h0100]));

    // Address wrap
    step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    guard = 0;
    while (q_count < 2 && guard < 20) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
      guard++;
    end
    chk("wrap_fill_timeout", 32'(guard < 20), 32'd1);
    chk("wrap_pc0", 32'(ins_pc), 32'hFFFF);
    chk("wrap_data0", 32'(ins_data), 32'(mem[16'hFFFF]));
    step(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("wrap_pc1", 32'(ins_pc), 32'h0000);
    chk("wrap_data1", 32'(ins_data), 32'(mem[16'h0000]));

    // Reset pulse mid READ
    guard = 0;
    while (mem_psen_n !== 1'b0 && guard < 20) begin
      step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
      guard++;
    end
    chk("rst_read_timeout", 32'(guard < 20), 32'd1);
    chk("rst_pre_valid", 32'(ins_valid), 32'd1);
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    exp_q.delete();
    exp_pc = 16'd0;
    @(posedge clk); #1;
    chk_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("restart_ale", 32'(mem_ale), 32'd1);
    chk("restart_addr", 32'(mem_addr), 32'h0000);

    // Randomized traffic against the sequential-stream model
    for (int c = 0; c < 3000; c++) begin
      logic        fe, jmp, ack, rdy;
      logic [15:0] ja;
      fe  = ($urandom_range(0, 9) < 8);
      jmp = ($urandom_range(0, 99) < 3);
      ack = $urandom_range(0, 1) == 1;
      rdy = ($urandom_range(0, 9) < 7);
      ja  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      step(fe, jmp, ja, ack, rdy);
      chk("rand_count_bound", 32'(q_count <= DEPTH), 32'd1);
      chk("rand_valid_vs_count", 32'(ins_valid), 32'(q_count != 0));
    end
    step(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    chk("pops_seen", 32'(n_pops > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
